pc_fetch: RTL and testbench

Instruction-fetch stage of the naive-mips pipeline. It owns the program counter, issues word fetches to instruction memory over a single-outstanding req/ack handshake, and drives `if_pc`/`if_inst` into the IF/ID register. `if_inst` arrives one cycle after the `if_pc` it belongs to, so the ID stage sees a matched pair. The stage also handles delayed-slot branch redirects, exception flushes, and stalls, including buffering of memory data that returns while the pipeline is stalled.

---
 rtl/pc_fetch_pkg.sv | 29 ++
 rtl/pc_fetch.sv | 142 ++++++++++++++
 tb/tb_pc_fetch.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared constants and state encodings
// for the instruction-fetch stage.
package pc_fetch_pkg;

    localparam logic [31:0] InitialPc = 32'h0000_0000;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // stall vector bit positions
    localparam int StallPc = 0;
    localparam int StallIf = 1;
    localparam int StallId = 2;

    localparam int FetchStateBus = 2;

    typedef enum logic [FetchStateBus-1:0] {
        FetchReset = 2'd0,
        FetchFetch = 2'd1,
        FetchHeld  = 2'd2,
        FetchDrain = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_fetch.sv
// pc_fetch: instruction-fetch stage. Owns the PC, runs a
// single-outstanding imem handshake and feeds IF/ID.
module pc_fetch
    import pc_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if
);

    fetch_state_e state;
    fetch_state_e state_nxt;

    logic [31:0] skid;
    logic [31:0] pend_pc;
    logic [31:0] drain_pc;
    logic        pend_vld;
    logic        discard;

    logic        fetch_ack;
    logic        have;
    logic        consume;
    logic        advance;
    logic        busy;
    logic [31:0] word;
    logic [31:0] redirect;

    logic        stall_unused;
    assign stall_unused = ^stall[5:3];

    assign imem_addr = if_pc;

    // Decode which word is available and whether the PC moves.
    always_comb begin
        fetch_ack = (state == FetchFetch) && imem_ack;
        have      = fetch_ack || (state == FetchHeld);
        word      = (state == FetchHeld) ? skid : imem_rdata;
        consume   = have && (stall[StallIf] == NoStop);
        advance   = consume && (stall[StallPc] == NoStop);
        busy      = imem_req && !imem_ack;
        if (branch_flag)
            redirect = branch_target_addr;
        else if (pend_vld)
            redirect = pend_pc;
        else
            redirect = seq_pc(if_pc);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst)
            state <= FetchReset;
        else
            state <= state_nxt;
    end

    // Next-state logic; flush overrides normal sequencing.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = busy ? FetchDrain : FetchFetch;
        end else begin
            unique case (state)
                FetchReset:
                    state_nxt = FetchFetch;
                FetchFetch:
                    if (imem_ack && stall[StallIf] == Stop)
                        state_nxt = FetchHeld;
                FetchHeld:
                    if (stall[StallIf] == NoStop)
                        state_nxt = FetchFetch;
                FetchDrain:
                    if (imem_ack)
                        state_nxt = FetchFetch;
                default:
                    state_nxt = FetchReset;
            endcase
        end
    end

    // Handshake outputs; a draining fetch never stalls the pipe.
    always_comb begin
        imem_req    = (state == FetchFetch) ||
                      (state == FetchDrain);
        discard     = (state == FetchDrain);
        stallreq_if = imem_req && !imem_ack && !discard;
    end

    // PC, IF/ID word, skid buffer and redirect registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if_pc    <= InitialPc;
            if_inst  <= ZeroWord;
            skid     <= ZeroWord;
            pend_vld <= 1'b0;
            pend_pc  <= InitialPc;
            drain_pc <= InitialPc;
        end else if (flush) begin
            if_inst  <= ZeroWord;
            skid     <= ZeroWord;
            pend_vld <= 1'b0;
            if (busy)
                drain_pc <= new_pc;
            else
                if_pc <= new_pc;
        end else begin
            if (discard && imem_ack)
                if_pc <= drain_pc;
            else if (advance)
                if_pc <= redirect;

            if (advance) begin
                pend_vld <= 1'b0;
            end else if (branch_flag) begin
                pend_vld <= 1'b1;
                pend_pc  <= branch_target_addr;
            end

            if (fetch_ack && stall[StallIf] == Stop)
                skid <= imem_rdata;

            if (consume)
                if_inst <= word;
            else if (state != FetchReset &&
                     !(stall[StallIf] == Stop &&
                       stall[StallId] == Stop))
                if_inst <= ZeroWord;
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed and random stimulus against a
// queue-based fetch model, with a scoreboard monitor.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        branch_flag;
    logic [31:0] branch_target_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;

    always #5 clk = ~clk;

    pc_fetch dut (
        .clk                (clk),
        .rst                (rst),
        .stall              (stall),
        .flush              (flush),
        .new_pc             (new_pc),
        .branch_flag        (branch_flag),
        .branch_target_addr (branch_target_addr),
        .imem_req           (imem_req),
        .imem_addr          (imem_addr),
        .imem_ack           (imem_ack),
        .imem_rdata         (imem_rdata),
        .if_pc              (if_pc),
        .if_inst            (if_inst),
        .stallreq_if        (stallreq_if)
    );

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        sreq;
        logic [31:0] inst;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;

    // reference model: plain variables and queues
    bit          m_known = 0;
    bit          m_live  = 0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_inst  = 32'h0;
    logic [31:0] hold_q[$];
    logic [31:0] redir_q[$];
    logic [31:0] pend_q[$];
    int          wait_left = 0;
    int          next_lat  = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4)
            return 32'h2402_0005;
        return a ^ 32'hC0DE_0001;
    endfunction

    task automatic dchk(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // one clock of stimulus plus model update
    task automatic cyc(input bit r, input logic [5:0] s,
                       input bit fl, input logic [31:0] np,
                       input bit br, input logic [31:0] bt);
        bit          req;
        bit          ack;
        bit          have;
        logic [31:0] rd;
        logic [31:0] w;
        @(negedge clk);
        req = m_live && (hold_q.size() == 0);
        ack = 0;
        if (req) begin
            if (wait_left == 0) begin
                ack = 1;
                wait_left = next_lat;
            end else begin
                wait_left--;
            end
        end
        rd = mem_word(m_pc);
        rst                = r;
        stall              = s;
        flush              = fl;
        new_pc             = np;
        branch_flag        = br;
        branch_target_addr = bt;
        imem_ack           = ack;
        imem_rdata         = ack ? rd : $urandom;
        if (m_known)
            expq.push_back('{req, m_pc,
                req && !ack && (redir_q.size() == 0),
                m_inst});

        if (!r) begin
            m_known = 1;
            m_live  = 0;
            m_pc    = 32'h0;
            m_inst  = 32'h0;
            hold_q.delete();
            redir_q.delete();
            pend_q.delete();
            wait_left = next_lat;
        end else if (fl) begin
            m_inst = 32'h0;
            m_live = 1;
            pend_q.delete();
            hold_q.delete();
            redir_q.delete();
            if (req && !ack)
                redir_q.push_back(np);
            else
                m_pc = np;
        end else begin
            if (br) begin
                pend_q.delete();
                pend_q.push_back(bt);
            end
            if (redir_q.size() != 0) begin
                if (ack)
                    m_pc = redir_q.pop_front();
                if (!(s[1] && s[2]))
                    m_inst = 32'h0;
            end else if (!m_live) begin
                m_live = 1;
            end else begin
                have = 0;
                w    = 32'h0;
                if (req && ack) begin
                    w    = rd;
                    have = 1;
                end else if (hold_q.size() != 0) begin
                    w    = hold_q[0];
                    have = 1;
                end
                if (have && !s[1]) begin
                    m_inst = w;
                    hold_q.delete();
                    if (!s[0]) begin
                        if (pend_q.size() != 0)
                            m_pc = pend_q.pop_front();
                        else
                            m_pc = m_pc + 32'd4;
                    end
                end else begin
                    if (have) begin
                        hold_q.delete();
                        hold_q.push_back(w);
                    end
                    if (!(s[1] && s[2]))
                        m_inst = 32'h0;
                end
            end
        end
    endtask

    task automatic idle(input logic [5:0] s);
        cyc(1, s, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic do_reset();
        cyc(0, 6'h0, 0, 32'h0, 0, 32'h0);
        cyc(0, 6'h0, 0, 32'h0, 0, 32'h0);
    endtask

    // scoreboard monitor: pop and compare every cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (imem_req !== e.req ||
                    imem_addr !== e.addr ||
                    if_pc !== e.addr ||
                    stallreq_if !== e.sreq ||
                    if_inst !== e.inst) begin
                    errors++;
                    $display("FAIL cyc t=%0t got req=%b addr=%h pc=%h sreq=%b inst=%h want req=%b pc=%h sreq=%b inst=%h",
                             $time, imem_req, imem_addr, if_pc,
                             stallreq_if, if_inst, e.req, e.addr,
                             e.sreq, e.inst);
                end
            end
        end
    end

    initial begin
        logic [5:0] s;
        rst = 1'b1;
        stall = 6'h0;
        flush = 1'b0;
        new_pc = 32'h0;
        branch_flag = 1'b0;
        branch_target_addr = 32'h0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;

        // reset, then zero-wait stream
        next_lat = 0;
        do_reset();
        #1;
        dchk("rst_pc", if_pc, 32'h0);
        dchk("rst_req", {31'h0, imem_req}, 32'h0);
        dchk("rst_inst", if_inst, 32'h0);
        idle(6'h0);
        for (int i = 0; i < 4; i++) begin
            idle(6'h0);
            #1;
            dchk("zw_pc", if_pc, 32'(4 * i));
            dchk("zw_inst", if_inst,
                 (i == 0) ? 32'h0 : mem_word(32'(4 * (i - 1))));
            dchk("zw_sreq", {31'h0, stallreq_if}, 32'h0);
        end

        // two wait states on 0x4
        do_reset();
        idle(6'h0);
        next_lat = 2;
        idle(6'h0);
        idle(6'b000011);
        #1;
        dchk("ws_sreq1", {31'h0, stallreq_if}, 32'h1);
        dchk("ws_pc1", if_pc, 32'h4);
        idle(6'b000011);
        #1;
        dchk("ws_sreq2", {31'h0, stallreq_if}, 32'h1);
        dchk("ws_inst2", if_inst, 32'h0);
        next_lat = 0;
        idle(6'h0);
        #1;
        dchk("ws_sreq3", {31'h0, stallreq_if}, 32'h0);
        dchk("ws_pc3", if_pc, 32'h4);
        idle(6'h0);
        #1;
        dchk("ws_inst4", if_inst, 32'h2402_0005);
        dchk("ws_pc4", if_pc, 32'h8);

        // ack under stall, then branch in delay slot
        do_reset();
        idle(6'h0);
        idle(6'h0);
        idle(6'b000111);
        idle(6'b000111);
        #1;
        dchk("sk_req", {31'h0, imem_req}, 32'h0);
        dchk("sk_pc", if_pc, 32'h4);
        idle(6'h0);
        #1;
        dchk("sk_req2", {31'h0, imem_req}, 32'h0);
        cyc(1, 6'h0, 0, 32'h0, 1, 32'h100);
        #1;
        dchk("sk_inst", if_inst, 32'h2402_0005);
        dchk("sk_addr", imem_addr, 32'h8);
        idle(6'h0);
        #1;
        dchk("br_pc", if_pc, 32'h100);
        dchk("br_slot", if_inst, mem_word(32'h8));
        idle(6'h0);
        #1;
        dchk("br_next", if_pc, 32'h104);

        // flush while 0xC is outstanding
        do_reset();
        idle(6'h0);
        idle(6'h0);
        idle(6'h0);
        next_lat = 2;
        idle(6'h0);
        cyc(1, 6'b000011, 1, 32'h180, 0, 32'h0);
        next_lat = 0;
        idle(6'h0);
        #1;
        dchk("fl_sreq", {31'h0, stallreq_if}, 32'h0);
        dchk("fl_addr", imem_addr, 32'hC);
        dchk("fl_inst", if_inst, 32'h0);
        idle(6'h0);
        idle(6'h0);
        #1;
        dchk("fl_new", imem_addr, 32'h180);
        dchk("fl_inst2", if_inst, 32'h0);

        // reset during a wait
        next_lat = 3;
        idle(6'h0);
        idle(6'h0);
        next_lat = 0;
        cyc(0, 6'h0, 0, 32'h0, 0, 32'h0);
        idle(6'h0);
        #1;
        dchk("rw_req", {31'h0, imem_req}, 32'h0);
        dchk("rw_pc", if_pc, 32'h0);
        dchk("rw_inst", if_inst, 32'h0);

        // PC wrap and misaligned branch target
        cyc(1, 6'h0, 1, 32'hFFFF_FFF8, 0, 32'h0);
        idle(6'h0);
        #1;
        dchk("wr_pc0", if_pc, 32'hFFFF_FFF8);
        idle(6'h0);
        idle(6'h0);
        #1;
        dchk("wr_pc2", if_pc, 32'h0);
        dchk("wr_inst", if_inst, mem_word(32'hFFFF_FFFC));
        cyc(1, 6'h0, 0, 32'h0, 1, 32'h103);
        idle(6'h0);
        #1;
        dchk("mis_pc", if_pc, 32'h103);

        // randomized traffic checked by the scoreboard
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(7))
                4:       s = 6'b000001;
                5:       s = 6'b000011;
                6:       s = 6'b000111;
                7:       s = 6'b001111;
                default: s = 6'b000000;
            endcase
            next_lat = ($urandom_range(2) == 0) ?
                       int'($urandom_range(3)) : 0;
            cyc(($urandom_range(199) != 0), s,
                ($urandom_range(29) == 0), $urandom & 32'hFFFF_FFFC,
                ($urandom_range(9) == 0), $urandom);
        end

        @(negedge clk);
        #3;
        dchk("sb_empty", 32'(expq.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
